// File: rtl/rgb_fade_pkg.sv
// Shared types and constants for the three-channel RGB PWM fader.
package rgb_fade_pkg;

  localparam int unsigned LEVEL_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } fade_state_t;

  localparam int unsigned CH_R = 0;
  localparam int unsigned CH_G = 1;
  localparam int unsigned CH_B = 2;
  localparam int unsigned N_CH = 3;

endpackage

// File: rtl/rgb_fade_channel.sv
// One colour channel: level register with +/-1 stepper, period-aligned
// shadow duty register and registered PWM comparator.
module rgb_fade_channel
  import rgb_fade_pkg::*;
#(
  parameter int unsigned LEVEL_W = LEVEL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_en,
  input  logic [LEVEL_W-1:0] target,
  input  logic [LEVEL_W-1:0] pcnt,
  input  logic               pcnt_wrap,
  output logic [LEVEL_W-1:0] level,
  output logic               at_target,
  output logic               pwm
);

  logic [LEVEL_W-1:0] duty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
      duty  <= '0;
      pwm   <= 1'b0;
    end else begin
      if (step_en) begin
        if (level < target)
          level <= level + 1'b1;
        else if (level > target)
          level <= level - 1'b1;
      end
      // Duty only changes at the period boundary so a period is never split.
      if (pcnt_wrap)
        duty <= level;
      pwm <= (pcnt < duty);
    end
  end

  assign at_target = (level == target);

endmodule

// File: rtl/rgb_pwm_fader.sv
// Three-channel PWM generator with linear fading toward handshaked targets;
// drives the PWM inputs of the iCE40 SB_RGBA_DRV.
module rgb_pwm_fader
  import rgb_fade_pkg::*;
#(
  parameter int unsigned FADE_LOG2 = 16,
  parameter int unsigned LEVEL_W   = LEVEL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LEVEL_W-1:0] tgt_r,
  input  logic [LEVEL_W-1:0] tgt_g,
  input  logic [LEVEL_W-1:0] tgt_b,
  input  logic               tgt_valid,
  output logic               tgt_ready,
  output logic               busy,
  output logic               done,
  output logic               pwm_r,
  output logic               pwm_g,
  output logic               pwm_b,
  output logic [LEVEL_W-1:0] level_r,
  output logic [LEVEL_W-1:0] level_g,
  output logic [LEVEL_W-1:0] level_b
);

  fade_state_t          state;
  logic [FADE_LOG2-1:0] presc;
  logic [LEVEL_W-1:0]   pcnt;
  logic                 tick;
  logic                 pcnt_wrap;
  logic                 step_en;
  logic                 accept;

  logic [LEVEL_W-1:0] tgt_in [N_CH];
  logic [LEVEL_W-1:0] tgt_q  [N_CH];
  logic [LEVEL_W-1:0] level  [N_CH];
  logic [N_CH-1:0]    at_tgt;
  logic [N_CH-1:0]    near;
  logic [N_CH-1:0]    differs;
  logic [N_CH-1:0]    pwm;

  assign tgt_in[CH_R] = tgt_r;
  assign tgt_in[CH_G] = tgt_g;
  assign tgt_in[CH_B] = tgt_b;

  assign tick      = &presc;
  assign pcnt_wrap = &pcnt;
  assign step_en   = (state == FADE) && tick;
  assign tgt_ready = ~busy;
  assign accept    = tgt_valid & tgt_ready;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [LEVEL_W:0] lv_x;
    logic [LEVEL_W:0] tg_x;

    rgb_fade_channel #(.LEVEL_W(LEVEL_W)) u_chan (
      .clk       (clk),
      .rst       (rst),
      .step_en   (step_en),
      .target    (tgt_q[ch]),
      .pcnt      (pcnt),
      .pcnt_wrap (pcnt_wrap),
      .level     (level[ch]),
      .at_target (at_tgt[ch]),
      .pwm       (pwm[ch])
    );

    // Widened compare: the channel lands on its target with this step, so
    // the FSM can release busy in the same cycle the last level updates.
    assign lv_x        = {1'b0, level[ch]};
    assign tg_x        = {1'b0, tgt_q[ch]};
    assign near[ch]    = at_tgt[ch] || (lv_x + 1'b1 == tg_x) || (tg_x + 1'b1 == lv_x);
    assign differs[ch] = (tgt_in[ch] != level[ch]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      pcnt  <= '0;
    end else begin
      presc <= presc + 1'b1;
      pcnt  <= pcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++)
        tgt_q[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            for (int unsigned i = 0; i < N_CH; i++)
              tgt_q[i] <= tgt_in[i];
            if (|differs) begin
              state <= FADE;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        FADE: begin
          if (tick && (&near)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_r   = pwm[CH_R];
  assign pwm_g   = pwm[CH_G];
  assign pwm_b   = pwm[CH_B];
  assign level_r = level[CH_R];
  assign level_g = level[CH_G];
  assign level_b = level[CH_B];

endmodule
